// File: rtl/bsg_tie_monitor.sv
// rtl/bsg_tie_monitor.sv - debounced checker for a tied-off constant bus with sticky status
module bsg_tie_monitor #(
    parameter int width_p     = 16,
    parameter bit tie_val_p   = 1'b0,
    parameter int debounce_p  = 2,
    parameter int cnt_width_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   en_i,
    input  logic [width_p-1:0]     data_i,
    input  logic                   clr_i,
    output logic                   v_o,
    output logic [width_p-1:0]     event_bits_o,
    input  logic                   yumi_i,
    output logic                   err_o,
    output logic [width_p-1:0]     err_mask_o,
    output logic [cnt_width_p-1:0] err_cnt_o
);

    localparam logic [1:0] idle_s  = 2'd0;
    localparam logic [1:0] arm_s   = 2'd1;
    localparam logic [1:0] fault_s = 2'd2;

    localparam int dcnt_w_lp = $clog2(debounce_p + 1);
    localparam logic [dcnt_w_lp-1:0] dcnt_last_lp = dcnt_w_lp'(debounce_p - 1);
    localparam logic [width_p-1:0]   tie_lp       = {width_p{tie_val_p}};

    logic [width_p-1:0]   data_r;
    logic [width_p-1:0]   mm;
    logic                 hit;
    logic [1:0]           state_r, state_n;
    logic [dcnt_w_lp-1:0] dcnt_r, dcnt_n;
    logic                 confirm;

    assign mm      = data_r ^ tie_lp;
    assign hit     = |mm;
    assign v_o     = (state_r == fault_s);
    assign confirm = (state_r != fault_s) && (state_n == fault_s);

    always_comb begin
        state_n = state_r;
        dcnt_n  = dcnt_r;
        case (state_r)
            idle_s: begin
                if (en_i && hit) begin
                    if (debounce_p == 1) begin
                        state_n = fault_s;
                    end else begin
                        state_n = arm_s;
                        dcnt_n  = dcnt_w_lp'(1);
                    end
                end
            end
            arm_s: begin
                if (!en_i || !hit) begin
                    state_n = idle_s;
                    dcnt_n  = '0;
                end else begin
                    dcnt_n = dcnt_r + 1'b1;
                    if (dcnt_r == dcnt_last_lp) begin
                        state_n = fault_s;
                    end
                end
            end
            fault_s: begin
                // An open event is only retired by the consumer, never by en_i.
                if (yumi_i) begin
                    state_n = idle_s;
                    dcnt_n  = '0;
                end
            end
            default: begin
                state_n = idle_s;
                dcnt_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_r       <= tie_lp;
            state_r      <= idle_s;
            dcnt_r       <= '0;
            event_bits_o <= '0;
        end else begin
            data_r  <= data_i;
            state_r <= state_n;
            dcnt_r  <= dcnt_n;
            if (confirm) begin
                event_bits_o <= mm;
            end
        end
    end

    // A clear landing on a confirmation edge still records that confirmation.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_o      <= 1'b0;
            err_mask_o <= '0;
            err_cnt_o  <= '0;
        end else if (confirm) begin
            err_o      <= 1'b1;
            err_mask_o <= (clr_i ? '0 : err_mask_o) | mm;
            if (clr_i) begin
                err_cnt_o <= cnt_width_p'(1);
            end else if (!(&err_cnt_o)) begin
                err_cnt_o <= err_cnt_o + 1'b1;
            end
        end else if (clr_i) begin
            err_o      <= 1'b0;
            err_mask_o <= '0;
            err_cnt_o  <= '0;
        end
    end

endmodule

// File: tb/tb_bsg_tie_monitor.sv
// tb/tb_bsg_tie_monitor.sv - scoreboard bench for bsg_tie_monitor with directed vectors
module tb_bsg_tie_monitor;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        en_i;
    logic [15:0] data_i;
    logic        clr_i;
    logic        v_o;
    logic [15:0] event_bits_o;
    logic        yumi_i;
    logic        err_o;
    logic [15:0] err_mask_o;
    logic [1:0]  err_cnt_o;

    bsg_tie_monitor #(
        .width_p    (16),
        .tie_val_p  (1'b0),
        .debounce_p (2),
        .cnt_width_p(2)
    ) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .en_i        (en_i),
        .data_i      (data_i),
        .clr_i       (clr_i),
        .v_o         (v_o),
        .event_bits_o(event_bits_o),
        .yumi_i      (yumi_i),
        .err_o       (err_o),
        .err_mask_o  (err_mask_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [15:0] bits;
        logic [1:0]  cnt;
        logic [15:0] mask;
    } ev_t;

    ev_t exp_q[$];
    ev_t e;
    int  tests = 0;
    int  fails = 0;
    bit  pending = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Each new event is compared once against the oldest expectation.
    always @(negedge clk_i) begin
        if (!reset_n_i) begin
            pending = 1'b0;
        end else begin
            if (v_o && !pending) begin
                pending = 1'b1;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: got bits %0h expected no event", event_bits_o);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_bits", {16'h0, event_bits_o}, {16'h0, e.bits});
                    check("ev_cnt", {30'h0, err_cnt_o}, {30'h0, e.cnt});
                    check("ev_mask", {16'h0, err_mask_o}, {16'h0, e.mask});
                    check("ev_err", {31'h0, err_o}, 32'h1);
                end
            end
            if (v_o && yumi_i) pending = 1'b0;
        end
    end

    task automatic do_event(input logic [15:0] d, input logic clr_c,
                            input logic [1:0] ecnt, input logic [15:0] emask);
        exp_q.push_back('{bits: d, cnt: ecnt, mask: emask});
        data_i = d;
        step();
        step();
        clr_i = clr_c;
        step();
        clr_i = 1'b0;
        check("do_event_v", {31'h0, v_o}, 32'h1);
        check("do_event_bits", {16'h0, event_bits_o}, {16'h0, d});
        yumi_i = 1'b1;
        data_i = 16'h0000;
        step();
        yumi_i = 1'b0;
        check("do_event_retire", {31'h0, v_o}, 32'h0);
    endtask

    initial begin
        reset_n_i = 1'b0;
        en_i      = 1'b1;
        data_i    = 16'h0000;
        clr_i     = 1'b0;
        yumi_i    = 1'b0;
        repeat (3) step();
        check("rst_v", {31'h0, v_o}, 32'h0);
        check("rst_bits", {16'h0, event_bits_o}, 32'h0);
        check("rst_err", {31'h0, err_o}, 32'h0);
        check("rst_mask", {16'h0, err_mask_o}, 32'h0);
        check("rst_cnt", {30'h0, err_cnt_o}, 32'h0);
        reset_n_i = 1'b1;

        // clean bus
        repeat (50) begin
            step();
            check("clean_bus", {28'h0, v_o, err_o, err_cnt_o}, 32'h0);
        end

        // single-cycle glitch shorter than the debounce window
        data_i = 16'h0010;
        step();
        data_i = 16'h0000;
        repeat (6) begin
            step();
            check("glitch_v", {31'h0, v_o}, 32'h0);
        end
        check("glitch_cnt", {30'h0, err_cnt_o}, 32'h0);
        check("glitch_err", {31'h0, err_o}, 32'h0);

        // persistent fault: cycle 0 now
        data_i = 16'h8001;
        exp_q.push_back('{bits: 16'h8001, cnt: 2'd1, mask: 16'h8001});
        step();
        step();
        check("lat_c2_v", {31'h0, v_o}, 32'h0);
        step();
        check("lat_c3_v", {31'h0, v_o}, 32'h1);
        repeat (9) begin
            step();
            check("hold_v", {31'h0, v_o}, 32'h1);
            check("hold_cnt", {30'h0, err_cnt_o}, 32'h1);
        end
        step();
        yumi_i = 1'b1;
        exp_q.push_back('{bits: 16'h8001, cnt: 2'd2, mask: 16'h8001});
        step();
        yumi_i = 1'b0;
        check("rearm_c14_v", {31'h0, v_o}, 32'h0);
        step();
        check("rearm_c15_v", {31'h0, v_o}, 32'h0);
        step();
        check("rearm_c16_v", {31'h0, v_o}, 32'h1);
        check("rearm_c16_cnt", {30'h0, err_cnt_o}, 32'h2);
        data_i = 16'h0100;
        yumi_i = 1'b1;
        exp_q.push_back('{bits: 16'h0100, cnt: 2'd3, mask: 16'h8101});
        step();
        yumi_i = 1'b0;
        check("switch_c17_v", {31'h0, v_o}, 32'h0);
        step();
        step();
        check("switch_c19_v", {31'h0, v_o}, 32'h1);
        check("switch_mask", {16'h0, err_mask_o}, 32'h8101);
        yumi_i = 1'b1;
        data_i = 16'h0000;
        step();
        yumi_i = 1'b0;
        check("switch_retire", {31'h0, v_o}, 32'h0);

        // saturation, then clear coincident with a confirmation
        do_event(16'h0002, 1'b0, 2'd3, 16'h8103);
        do_event(16'h0004, 1'b0, 2'd3, 16'h8107);
        check("sat_cnt", {30'h0, err_cnt_o}, 32'h3);
        do_event(16'h0020, 1'b1, 2'd1, 16'h0020);
        check("clr_win_err", {31'h0, err_o}, 32'h1);
        check("clr_win_cnt", {30'h0, err_cnt_o}, 32'h1);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        check("clr_err", {31'h0, err_o}, 32'h0);
        check("clr_mask", {16'h0, err_mask_o}, 32'h0);
        check("clr_cnt", {30'h0, err_cnt_o}, 32'h0);
        yumi_i = 1'b1;
        step();
        step();
        yumi_i = 1'b0;
        check("stray_yumi_v", {31'h0, v_o}, 32'h0);
        check("stray_yumi_cnt", {30'h0, err_cnt_o}, 32'h0);

        // asynchronous reset while an event is open
        data_i = 16'h0040;
        exp_q.push_back('{bits: 16'h0040, cnt: 2'd1, mask: 16'h0040});
        step();
        step();
        step();
        check("pre_rst_v", {31'h0, v_o}, 32'h1);
        @(negedge clk_i);
        #2;
        reset_n_i = 1'b0;
        #1;
        check("arst_v", {31'h0, v_o}, 32'h0);
        check("arst_bits", {16'h0, event_bits_o}, 32'h0);
        check("arst_err", {31'h0, err_o}, 32'h0);
        check("arst_mask", {16'h0, err_mask_o}, 32'h0);
        check("arst_cnt", {30'h0, err_cnt_o}, 32'h0);
        data_i = 16'h0000;
        step();
        step();
        reset_n_i = 1'b1;
        step();
        check("no_replay_v", {31'h0, v_o}, 32'h0);

        // disabled checker ignores a mismatch
        en_i   = 1'b0;
        data_i = 16'hffff;
        repeat (10) begin
            step();
            check("disabled_v", {31'h0, v_o}, 32'h0);
            check("disabled_err", {31'h0, err_o}, 32'h0);
        end
        step();
        check("queue_drained", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
